// File: rtl/phase_operand_selector.sv
// Steps through NUM_PHASES phases, registering one source-bus operand per phase chosen by select codes latched at start.
// Latency: one clock from the unstalled RUN edge of a phase to its operand; stall freezes the sequencer and holds the outputs.
module phase_operand_selector #(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 4,
  parameter int NUM_PHASES = 3,
  parameter int SEL_W      = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        stall,
  input  logic [NUM_PHASES*SEL_W-1:0] sel_vec,
  input  logic [NUM_SRC*WIDTH-1:0]    src_bus,
  output logic [WIDTH-1:0]            operand,
  output logic                        operand_valid,
  output logic [2:0]                  operand_phase,
  output logic                        busy,
  output logic                        done,
  output logic                        sel_err
);

  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state_q, state_d;
  logic [PH_W-1:0]               phase_q, phase_d;
  logic [NUM_PHASES*SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]              sel_arr [NUM_PHASES];
  logic [SEL_W-1:0]              cur_code;
  logic [WIDTH-1:0]              picked;
  logic                          illegal;
  logic                          last_phase;
  logic                          advance;

  logic [WIDTH-1:0]              operand_d;
  logic                          valid_d;
  logic [2:0]                    oph_d;
  logic                          done_d;
  logic                          err_d;

  for (genvar p = 0; p < NUM_PHASES; p++) begin : g_sel
    assign sel_arr[p] = sel_q[p*SEL_W +: SEL_W];
  end

  assign cur_code   = sel_arr[phase_q];
  assign last_phase = (phase_q == PH_W'(NUM_PHASES - 1));
  assign illegal    = (cur_code > SEL_W'(NUM_SRC));
  assign advance    = (state_q == RUN) && !stall;
  assign busy       = (state_q == RUN);

  // Code 0 and illegal codes both leave picked at zero.
  always_comb begin
    picked = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (cur_code == SEL_W'(k + 1)) picked = src_bus[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      sel_q         <= '0;
      operand       <= '0;
      operand_valid <= 1'b0;
      operand_phase <= '0;
      done          <= 1'b0;
      sel_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      sel_q         <= sel_d;
      operand       <= operand_d;
      operand_valid <= valid_d;
      operand_phase <= oph_d;
      done          <= done_d;
      sel_err       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = sel_vec;
          phase_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (last_phase) begin
            phase_d = '0;
            state_d = IDLE;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    operand_d = operand;
    oph_d     = operand_phase;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = sel_err;
    if (state_q == IDLE && start) err_d = 1'b0;
    if (advance) begin
      operand_d = picked;
      oph_d     = 3'(phase_q);
      valid_d   = 1'b1;
      done_d    = last_phase;
      if (illegal) err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_operand_selector.sv
// Randomised and directed bench for phase_operand_selector; a driver pushes expected operands, a negedge monitor checks them.
module tb_phase_operand_selector;

  localparam int WIDTH = 32;
  localparam int NSRC  = 4;
  localparam int NP    = 3;
  localparam int SW    = 4;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                stall = 1'b0;
  logic [NP*SW-1:0]    sel_vec = '0;
  logic [WIDTH-1:0]    src [NSRC];
  logic [NSRC*WIDTH-1:0] src_bus;
  logic [WIDTH-1:0]    operand;
  logic                operand_valid;
  logic [2:0]          operand_phase;
  logic                busy;
  logic                done;
  logic                sel_err;

  assign src_bus = {src[3], src[2], src[1], src[0]};

  phase_operand_selector #(.WIDTH(WIDTH), .NUM_SRC(NSRC), .NUM_PHASES(NP), .SEL_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .sel_vec(sel_vec), .src_bus(src_bus), .operand(operand),
    .operand_valid(operand_valid), .operand_phase(operand_phase),
    .busy(busy), .done(done), .sel_err(sel_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] op;
    logic [2:0]  ph;
    logic        dn;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   exp_done = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every valid must match the oldest expected entry, on the expected cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (operand_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: got valid=1 expected no output (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("operand", operand, e.op);
          chk("operand_phase", 32'(operand_phase), 32'(e.ph));
          chk("done", 32'(done), 32'(e.dn));
          chk("sel_err", 32'(sel_err), 32'(e.err));
          chk("valid_cycle", cyc, e.cyc);
        end
        if (done) done_seen++;
      end else if (done) begin
        total++; bad++;
        $display("FAIL done_without_valid: got done=1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_src();
    for (int k = 0; k < NSRC; k++) src[k] = $urandom;
  endtask

  function automatic logic [31:0] ref_operand(input logic [3:0] code);
    if (code == 0) return 32'h0;
    if (code <= NSRC) return src[code - 1];
    return 32'h0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      stall = 1'($urandom_range(1));
      step();
      chk("busy_idle", 32'(busy), 32'd0);
    end
    stall = 1'b0;
  endtask

  // One sequence: start edge, then each phase consumed on its first unstalled edge.
  task automatic run_seq(input logic [NP*SW-1:0] sels, input int st_ph, input int st_len,
                         input bit rnd, input bit chg, input bit bstart);
    logic        err_m;
    logic [3:0]  code;
    exp_t        e;
    int          ns;
    err_m = 1'b0;
    start = 1'b1;
    sel_vec = sels;
    stall = rnd ? 1'($urandom_range(1)) : 1'b0;
    step();
    start = 1'b0;
    stall = 1'b0;
    sel_vec = NP*SW'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared_on_start", 32'(sel_err), 32'd0);
    for (int p = 0; p < NP; p++) begin
      ns = (p == st_ph) ? st_len : 0;
      if (rnd && $urandom_range(3) == 0) ns = $urandom_range(1, 2);
      for (int s = 0; s < ns; s++) begin
        stall = 1'b1;
        if (chg && s == 0) src[1] = 32'h2222;
        if (rnd) rand_src();
        step();
        chk("busy_stall", 32'(busy), 32'd1);
      end
      stall = 1'b0;
      if (bstart && p == 1) begin
        start = 1'b1;
        sel_vec = ~sels;
      end
      if (rnd) rand_src();
      code = sels[p*SW +: SW];
      if (code > NSRC) err_m = 1'b1;
      e.op  = ref_operand(code);
      e.ph  = 3'(p);
      e.dn  = (p == NP - 1);
      e.err = err_m;
      e.cyc = 32'(cyc + 1);
      sb.push_back(e);
      if (p == NP - 1) exp_done++;
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    int d0;
    logic [NP*SW-1:0] rs;
    src[0] = 32'h1000; src[1] = 32'h2000; src[2] = 32'h0040; src[3] = 32'hDEAD;

    #2;
    chk("rst_operand", operand, 32'h0);
    chk("rst_valid", 32'(operand_valid), 32'd0);
    chk("rst_phase", 32'(operand_phase), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    step();
    reset_n = 1'b1;
    idle(2);

    // Basic: phases select src0, src1, src2.
    run_seq({4'd3, 4'd2, 4'd1}, -1, 0, 0, 0, 0);
    idle(2);
    chk("hold_operand_idle", operand, 32'h0040);
    chk("hold_phase_idle", 32'(operand_phase), 32'd2);

    // Two-cycle stall during phase 1 with src1 updated mid-stall.
    run_seq({4'd3, 4'd2, 4'd1}, 1, 2, 0, 1, 0);
    idle(2);
    src[1] = 32'h2000;

    // Code 0 and an illegal code; flag must stick into IDLE.
    run_seq({4'd4, 4'd7, 4'd0}, -1, 0, 0, 0, 0);
    idle(3);
    chk("sel_err_sticky", 32'(sel_err), 32'd1);

    // Start while busy is ignored.
    run_seq({4'd3, 4'd2, 4'd1}, -1, 0, 0, 0, 1);
    idle(2);

    // Back-to-back: second start lands in the done cycle.
    run_seq({4'd1, 4'd4, 4'd2}, -1, 0, 0, 0, 0);
    run_seq({4'd2, 4'd3, 4'd4}, -1, 0, 0, 0, 0);
    idle(2);

    // Asynchronous reset in the middle of phase 1.
    d0 = done_seen;
    start = 1'b1;
    sel_vec = {4'd3, 4'd2, 4'd1};
    step();
    start = 1'b0;
    sb.push_back('{op: 32'h1000, ph: 3'd0, dn: 1'b0, err: 1'b0, cyc: 32'(cyc + 1)});
    step();
    #5;
    reset_n = 1'b0;
    #1;
    chk("arst_operand", operand, 32'h0);
    chk("arst_valid", 32'(operand_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    step();
    step();
    chk("arst_held_busy", 32'(busy), 32'd0);
    chk("arst_no_done", 32'(done_seen), 32'(d0));
    reset_n = 1'b1;
    idle(1);
    run_seq({4'd3, 4'd2, 4'd1}, -1, 0, 0, 0, 0);

    // Randomised sequences with live source changes, stalls and random gaps.
    for (int n = 0; n < 200; n++) begin
      for (int p = 0; p < NP; p++) rs[p*SW +: SW] = 4'($urandom_range(0, 6));
      run_seq(rs, -1, 0, 1, 0, 1'($urandom_range(3) == 0));
      if ($urandom_range(2) != 0) idle($urandom_range(0, 3));
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
